// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the two-port memory arbiter.
//   - ADDR_W / DATA_W : width of the memory_control address and data buses
//   - PORT_IF / PORT_LS : port indices (instruction fetch / load-store)
//   - arb_state_e : FSM state encoding
//   - arb_req_t : one latched request (port, direction, address, write data)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic              port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } arb_req_t;

    // Builds the latched request for a given port from that port's inputs.
    function automatic arb_req_t make_req(
        input logic              port,
        input logic              we,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        arb_req_t r;
        r.port  = port;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
//   Purely combinational two-way arbiter.
//   Ports:
//     req[1:0]    in   request vector, bit N = port N
//     last_grant  in   port that won the previous transaction
//     fixed_prio  in   1 = port 1 wins every tie, 0 = alternate on ties
//     grant       out  winning port index (meaningful only when valid = 1)
//     valid       out  at least one port is requesting
// ---------------------------------------------------------------------------
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = PORT_IF;
        unique case (req)
            2'b01:   grant = PORT_IF;
            2'b10:   grant = PORT_LS;
            // Tie: fixed priority favours the load/store port, otherwise the
            // port that did not win last time goes next.
            2'b11:   grant = fixed_prio ? PORT_LS : ~last_grant;
            default: grant = PORT_IF;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the single memory_control request port between the instruction
//   fetch port (0) and the load/store port (1). One transaction at a time:
//   arbitrate, latch the winner, pulse mem_request for one cycle, wait for the
//   matching completion (or abort on timeout), then pulse the winner's done.
//
//   Ports:
//     clk, reset                 system clock, synchronous active-high reset
//     pN_req/we/addr/wdata       requester N inputs, held stable until pN_done
//     pN_done                    one-cycle completion pulse to requester N
//     pN_rdata                   read data, valid with pN_done, held after
//     mem_request_address/type   latched address / direction to memory_control
//     mem_request                one-cycle request pulse (ISSUE only)
//     mem_data_out               latched write data to memory_control
//     mem_memory_in              read data from memory_control
//     mem_memory_ready           read completion from memory_control
//     mem_write_complete         write completion from memory_control
//     busy                       high whenever not IDLE
//     timeout_err                sticky abort flag, cleared only by reset
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no transaction; arbitrate and latch the winner when any req
//   ISSUE | mem_request pulse from the latched request; wait counter cleared
//   WAIT  | waiting for completion matching latched type, or timeout abort
//   DONE  | done pulse to the granted port; last_grant updated
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_request_address,
    output logic              mem_request_type,
    output logic              mem_request,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_memory_in,
    input  logic              mem_memory_ready,
    input  logic              mem_write_complete,

    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e        state;
    arb_state_e        state_next;

    arb_req_t          cur;
    logic              last_grant;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_inc;

    logic              arb_grant;
    logic              arb_valid;
    logic              complete;
    logic              timeout_hit;
    logic              capture_rd;
    logic [DATA_W-1:0] rdata_next;

    rr_arbiter_2 u_rr_arbiter_2 (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO != 0),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Only the completion that matches the latched direction counts.
    assign complete     = cur.we ? mem_write_complete : mem_memory_ready;

    // wait_cnt_inc is the number of WAIT cycles spent including the current
    // one, so the abort lands on the TIMEOUT_CYCLES-th WAIT cycle. The
    // register never exceeds TIMEOUT_CYCLES because ISSUE clears it.
    assign wait_cnt_inc = wait_cnt + CNT_W'(1);
    assign timeout_hit  = (wait_cnt_inc == CNT_TERM);

    // A read that ends in WAIT always updates the port's rdata: memory data
    // on completion, zero on abort. Completion wins over a same-cycle abort.
    assign capture_rd   = (state == WAIT) && !cur.we && (complete || timeout_hit);
    assign rdata_next   = complete ? mem_memory_in : '0;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (arb_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (complete || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy        = (state != IDLE);
        mem_request = (state == ISSUE);
        p0_done     = (state == DONE) && (cur.port == PORT_IF);
        p1_done     = (state == DONE) && (cur.port == PORT_LS);
    end

    // The memory-side buses come straight from the latch and therefore hold
    // their value outside ISSUE; mem_request alone qualifies them.
    assign mem_request_address = cur.addr;
    assign mem_request_type    = cur.we;
    assign mem_data_out        = cur.wdata;

    // -----------------------------------------------------------------------
    // Request latch, arbitration history, wait counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= '0;
            last_grant <= PORT_LS;
            wait_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        cur <= (arb_grant == PORT_LS)
                             ? make_req(PORT_LS, p1_we, p1_addr, p1_wdata)
                             : make_req(PORT_IF, p0_we, p0_addr, p0_wdata);
                    end
                end
                ISSUE:   wait_cnt   <= '0;
                WAIT:    wait_cnt   <= wait_cnt_inc;
                DONE:    last_grant <= cur.port;
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Read data return and sticky timeout flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (capture_rd) begin
                if (cur.port == PORT_LS) begin
                    p1_rdata <= rdata_next;
                end else begin
                    p0_rdata <= rdata_next;
                end
            end
            if ((state == WAIT) && !complete && timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
